// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and default widths for the register-file write arbiter.
package regfile_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;
  localparam int DEF_NREQ = 3;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int GID_W = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant.
import regfile_pkg::*;
module rr_arbiter #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GID_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o
);
  logic found;
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_i[(int'(last_i) + k) % NREQ]) begin
        gnt_o[(int'(last_i) + k) % NREQ] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-sweeps the register file after reset/clear, then arbitrates writers round-robin.
import regfile_pkg::*;
module regfile_write_arbiter #(
  parameter int NREQ = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_dst,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dst,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     busy,
  output logic [GID_W-1:0]         grant_id
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, dst_q;
  logic [DATA_W-1:0] data_q;
  logic [GID_W-1:0] last_q, grant_q, gidx;
  logic [NREQ-1:0] gnt, ready;
  logic we_q, accept, sweep;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (req_valid),
    .last_i(last_q),
    .gnt_o (gnt)
  );
  always_comb begin
    ready = (state_q == RUN && !clear_req && !rst) ? gnt : '0;
    accept = |ready;
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (ready[i]) gidx = GID_W'(i);
    state_d = clear_req ? CLEAR : (state_q == CLEAR && cnt_q == ADDR_W'(NREGS - 1)) ? RUN : state_q;
    cnt_d = (clear_req || state_q == RUN) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      last_q <= GID_W'(NREQ - 1);
      grant_q <= '0;
      we_q <= 1'b0;
      dst_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= accept;
      if (accept) begin
        last_q <= gidx;
        grant_q <= gidx;
        dst_q <= req_dst[gidx*ADDR_W +: ADDR_W];
        data_q <= req_data[gidx*DATA_W +: DATA_W];
      end else if (state_q == CLEAR) begin
        dst_q <= cnt_q;
        data_q <= '0;
      end
    end
  end
  // Sweep writes come straight from the counter so address 0 lands on the first cycle after reset.
  assign sweep = !rst && state_q == CLEAR;
  assign req_ready = ready;
  assign busy = rst || state_q == CLEAR;
  assign rf_we = sweep || (!rst && we_q);
  assign rf_dst = rst ? '0 : sweep ? cnt_q : dst_q;
  assign rf_data = (rst || sweep) ? '0 : data_q;
  assign grant_id = rst ? '0 : grant_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;
  logic clk, rst, clear_req;
  logic [2:0] req_valid, req_ready;
  logic [11:0] req_dst;
  logic [23:0] req_data;
  logic rf_we, busy;
  logic [3:0] rf_dst;
  logic [7:0] rf_data;
  logic [1:0] grant_id;
  int checks, passes;
  int m_left, m_ptr;
  bit m_pend;
  logic [3:0] m_pdst, m_hdst;
  logic [7:0] m_pdata, m_hdata;
  logic [1:0] m_pgid, m_hgid;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .req_valid(req_valid),
    .req_dst(req_dst), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_left = sweep writes still to show (address is 16-m_left), m_pend = a transfer shows now.
  function automatic int winner();
    if (rst || clear_req || m_left > 0) return -1;
    for (int k = 1; k <= 3; k++) if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction
  function automatic logic [2:0] f_ready();
    return winner() < 0 ? 3'b000 : 3'(1 << winner());
  endfunction
  function automatic logic f_we();
    return !rst && (m_left > 0 || m_pend);
  endfunction
  function automatic logic [3:0] f_dst();
    return rst ? 4'd0 : m_left > 0 ? 4'(16 - m_left) : m_pend ? m_pdst : m_hdst;
  endfunction
  function automatic logic [7:0] f_data();
    return (rst || m_left > 0) ? 8'd0 : m_pend ? m_pdata : m_hdata;
  endfunction
  function automatic logic [1:0] f_gid();
    return rst ? 2'd0 : (m_left == 0 && m_pend) ? m_pgid : m_hgid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 16;
      m_ptr <= 2;
      m_pend <= 1'b0;
      m_hdst <= '0;
      m_hdata <= '0;
      m_hgid <= '0;
    end else begin
      m_hdst <= f_dst();
      m_hdata <= f_data();
      m_hgid <= f_gid();
      m_pend <= winner() >= 0;
      if (winner() >= 0) begin
        m_ptr <= winner();
        m_pdst <= req_dst[winner()*4 +: 4];
        m_pdata <= req_data[winner()*8 +: 8];
        m_pgid <= 2'(winner());
      end
      m_left <= clear_req ? 16 : (m_left > 0 ? m_left - 1 : 0);
    end
  end

  task automatic set(input logic r, input logic c, input logic [2:0] v, input logic [11:0] d, input logic [23:0] dt);
    @(negedge clk);
    rst = r;
    clear_req = c;
    req_valid = v;
    req_dst = d;
    req_data = dt;
    #1;
  endtask

  task automatic test_reset();
    set(1, 0, 3'b111, 12'h321, 24'h332211);
    set(1, 1, 3'b111, 12'h321, 24'h332211);
    checks++;
    if (rf_we !== 1'b0 || rf_dst !== 4'd0 || rf_data !== 8'd0 || grant_id !== 2'd0)
      $display("FAIL reset_rf: we=%b dst=%0d data=%h gid=%0d, expected all zero", rf_we, rf_dst, rf_data, grant_id);
    else passes++;
    checks++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b expected 000", req_ready); else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passes++;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      set(0, 0, 3'b000, 12'h0, 24'h0);
      checks++;
      if (rf_we !== 1'b1 || rf_dst !== 4'(i) || rf_data !== 8'd0 || busy !== 1'b1)
        $display("FAIL sweep_%0d: we=%b dst=%0d data=%h busy=%b, expected 1/%0d/00/1", i, rf_we, rf_dst, rf_data, busy, i);
      else passes++;
    end
    set(0, 0, 3'b000, 12'h0, 24'h0);
    checks++;
    if (busy !== 1'b0 || rf_we !== 1'b0) $display("FAIL sweep_end: busy=%b we=%b expected 0/0", busy, rf_we); else passes++;
  endtask

  task automatic test_all_valid();
    for (int k = 0; k < 6; k++) begin
      set(0, 0, 3'b111, 12'h321, 24'h332211);
      checks++;
      if (req_ready !== 3'(1 << (k % 3))) $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, 3'(1 << (k % 3)));
      else passes++;
      if (k > 0) begin
        checks++;
        if (rf_we !== 1'b1 || rf_dst !== 4'((k - 1) % 3 + 1) || rf_data !== 8'(((k - 1) % 3 + 1) * 17) || grant_id !== 2'((k - 1) % 3))
          $display("FAIL rr_write_%0d: we=%b dst=%0d data=%h gid=%0d expected 1/%0d/%h/%0d", k, rf_we, rf_dst, rf_data, grant_id,
                   (k - 1) % 3 + 1, 8'(((k - 1) % 3 + 1) * 17), (k - 1) % 3);
        else passes++;
      end
    end
    set(0, 0, 3'b000, 12'h321, 24'h332211);
    checks++;
    if (rf_we !== 1'b1 || rf_dst !== 4'd3 || rf_data !== 8'h33 || grant_id !== 2'd2 || req_ready !== 3'b000)
      $display("FAIL rr_last: we=%b dst=%0d data=%h gid=%0d ready=%b expected 1/3/33/2/000", rf_we, rf_dst, rf_data, grant_id, req_ready);
    else passes++;
  endtask

  task automatic test_single();
    set(0, 0, 3'b100, 12'h579, 24'hA51234);
    checks++;
    if (req_ready !== 3'b100) $display("FAIL single_ready: got %b expected 100", req_ready); else passes++;
    set(0, 0, 3'b000, 12'h579, 24'hA51234);
    checks++;
    if (rf_we !== 1'b1 || rf_dst !== 4'd5 || rf_data !== 8'hA5 || grant_id !== 2'd2)
      $display("FAIL single_write: we=%b dst=%0d data=%h gid=%0d expected 1/5/a5/2", rf_we, rf_dst, rf_data, grant_id);
    else passes++;
    set(0, 0, 3'b000, 12'h000, 24'h000000);
    checks++;
    if (rf_we !== 1'b0 || rf_dst !== 4'd5 || rf_data !== 8'hA5 || grant_id !== 2'd2)
      $display("FAIL single_hold: we=%b dst=%0d data=%h gid=%0d expected 0/5/a5/2", rf_we, rf_dst, rf_data, grant_id);
    else passes++;
  endtask

  task automatic test_clear_coincident();
    set(0, 1, 3'b001, 12'h00C, 24'h0000C3);
    checks++;
    if (req_ready !== 3'b000) $display("FAIL clr_ready: got %b expected 000", req_ready); else passes++;
    for (int i = 0; i < 16; i++) begin
      set(0, 0, 3'b001, 12'h00C, 24'h0000C3);
      checks++;
      if (rf_we !== 1'b1 || rf_dst !== 4'(i) || busy !== 1'b1 || req_ready !== 3'b000)
        $display("FAIL clr_sweep_%0d: we=%b dst=%0d busy=%b ready=%b expected 1/%0d/1/000", i, rf_we, rf_dst, busy, req_ready, i);
      else passes++;
    end
    set(0, 0, 3'b001, 12'h00C, 24'h0000C3);
    checks++;
    if (busy !== 1'b0 || req_ready !== 3'b001) $display("FAIL clr_after: busy=%b ready=%b expected 0/001", busy, req_ready); else passes++;
    set(0, 0, 3'b000, 12'h000, 24'h000000);
    checks++;
    if (rf_we !== 1'b1 || rf_dst !== 4'hC || rf_data !== 8'hC3 || grant_id !== 2'd0)
      $display("FAIL clr_write: we=%b dst=%0d data=%h gid=%0d expected 1/12/c3/0", rf_we, rf_dst, rf_data, grant_id);
    else passes++;
  endtask

  task automatic test_reset_mid_sweep();
    int writes;
    set(0, 1, 3'b000, 12'h0, 24'h0);
    for (int i = 0; i < 7; i++) set(0, 0, 3'b000, 12'h0, 24'h0);
    set(1, 0, 3'b000, 12'h0, 24'h0);
    checks++;
    if (rf_we !== 1'b0 || rf_dst !== 4'd0 || busy !== 1'b1)
      $display("FAIL rst_mid: we=%b dst=%0d busy=%b expected 0/0/1", rf_we, rf_dst, busy);
    else passes++;
    writes = 0;
    for (int i = 0; i < 16; i++) begin
      set(0, 0, 3'b000, 12'h0, 24'h0);
      if (rf_we === 1'b1 && rf_dst === 4'(i)) writes++;
    end
    set(0, 0, 3'b000, 12'h0, 24'h0);
    if (rf_we === 1'b1) writes++;
    checks++;
    if (writes !== 16 || busy !== 1'b0) $display("FAIL rst_restart: writes=%0d busy=%b expected 16/0", writes, busy); else passes++;
  endtask

  task automatic test_clear_mid_sweep();
    int bad;
    set(0, 1, 3'b000, 12'h0, 24'h0);
    for (int i = 0; i < 10; i++) set(0, 0, 3'b000, 12'h0, 24'h0);
    set(0, 1, 3'b000, 12'h0, 24'h0);
    checks++;
    if (rf_we !== 1'b1 || rf_dst !== 4'd10 || busy !== 1'b1)
      $display("FAIL clr_mid_10: we=%b dst=%0d busy=%b expected 1/10/1", rf_we, rf_dst, busy);
    else passes++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      set(0, 0, 3'b000, 12'h0, 24'h0);
      if (rf_we !== 1'b1 || rf_dst !== 4'(i) || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL clr_mid_restart: %0d bad sweep cycles, expected 0", bad); else passes++;
    set(0, 0, 3'b000, 12'h0, 24'h0);
    checks++;
    if (busy !== 1'b0) $display("FAIL clr_mid_end: busy=%b expected 0", busy); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set($urandom_range(0, 80) == 0, $urandom_range(0, 24) == 0, 3'($urandom), 12'($urandom), 24'($urandom));
      checks++;
      if (req_ready !== f_ready()) $display("FAIL rand_ready @%0d: got %b expected %b", n, req_ready, f_ready()); else passes++;
      checks++;
      if (rf_we !== f_we() || busy !== (rst || m_left > 0))
        $display("FAIL rand_we_busy @%0d: we=%b busy=%b expected %b/%b", n, rf_we, busy, f_we(), rst || m_left > 0);
      else passes++;
      checks++;
      if (rf_dst !== f_dst() || rf_data !== f_data() || grant_id !== f_gid())
        $display("FAIL rand_rf @%0d: dst=%0d data=%h gid=%0d expected %0d/%h/%0d", n, rf_dst, rf_data, grant_id, f_dst(), f_data(), f_gid());
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    clear_req = 1'b0;
    req_valid = '0;
    req_dst = '0;
    req_data = '0;
    test_reset();
    test_sweep();
    test_all_valid();
    test_single();
    test_clear_coincident();
    test_reset_mid_sweep();
    test_clear_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
